// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - 2-FF synchroniser and per-bit debouncer for board slide switches
// Also emits a change pulse and a saturating change counter for debug.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clear_count,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [7:0]       change_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     accept;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  // A bit is accepted once sync2 has disagreed with sw_stable for DEBOUNCE_CYCLES edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          sw_stable[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed   <= 1'b0;
      change_count <= 8'h00;
    end else begin
      sw_changed <= |accept;
      if (clear_count) begin
        change_count <= 8'h00;
      end else if (sw_changed && (change_count != 8'hFF)) begin
        change_count <= change_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
// A window-based reference model is compared on every falling edge, plus literal spot checks.
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int D = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic         clear_count = 1'b0;
  logic [W-1:0] sw_stable;
  logic         sw_changed;
  logic [7:0]   change_count;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)) dut (
    .clock(clock), .reset_n(reset_n), .sw_raw(sw_raw), .clear_count(clear_count),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .change_count(change_count)
  );

  always #5 clock = ~clock;

  // Model: a bit flips when the last D synchronised samples all disagree with it.
  logic [W-1:0] m_s1, m_s2, m_stable;
  logic         m_changed;
  logic [7:0]   m_count;
  logic [W-1:0] hist [$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_changed = 1'b0; m_count = 8'h00;
      hist.delete();
    end else begin
      logic [W-1:0] upd;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      upd = '0;
      for (int b = 0; b < W; b++) begin
        logic all_differ;
        all_differ = (hist.size() == D);
        foreach (hist[k]) if (hist[k][b] == m_stable[b]) all_differ = 1'b0;
        upd[b] = all_differ;
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
      if (clear_count) m_count = 8'h00;
      else if (m_changed && m_count != 8'hFF) m_count = m_count + 8'h01;
      m_changed = |upd;
      m_stable  = m_stable ^ upd;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model_sw_stable", 32'(sw_stable), 32'(m_stable));
    check("model_sw_changed", 32'(sw_changed), 32'(m_changed));
    check("model_change_count", 32'(change_count), 32'(m_count));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: in reset with all switches high
    sw_raw = 4'hF;
    edges(3);
    check("reset_stable", 32'(sw_stable), 32'h0);
    check("reset_changed", 32'(sw_changed), 32'h0);
    check("reset_count", 32'(change_count), 32'h0);

    // 2: release with 4'h5 held; accepted on the 10th edge
    sw_raw = 4'h5;
    #1 reset_n = 1'b1;
    edges(9);
    check("latency_edge9", 32'(sw_stable), 32'h0);
    edges(1);
    check("latency_edge10", 32'(sw_stable), 32'h5);
    check("first_pulse", 32'(sw_changed), 32'h1);
    edges(1);
    check("pulse_width", 32'(sw_changed), 32'h0);
    check("first_count", 32'(change_count), 32'h1);

    // 3: 5-cycle glitch on bit 1 is rejected
    sw_raw = 4'h7;
    edges(5);
    sw_raw = 4'h5;
    edges(15);
    check("glitch_stable", 32'(sw_stable), 32'h5);
    check("glitch_count", 32'(change_count), 32'h1);

    // 4: all bits change together
    sw_raw = 4'hA;
    edges(10);
    check("multi_stable", 32'(sw_stable), 32'hA);
    check("multi_pulse", 32'(sw_changed), 32'h1);
    edges(1);
    check("multi_count", 32'(change_count), 32'h2);

    // 5: saturate, then clear on the same cycle a pulse is seen
    for (int n = 0; n < 300; n++) begin
      sw_raw = ~sw_raw;
      edges(11);
    end
    check("saturated", 32'(change_count), 32'hFF);
    sw_raw = ~sw_raw;
    edges(10);
    check("pulse_before_clear", 32'(sw_changed), 32'h1);
    clear_count = 1'b1;
    edges(1);
    clear_count = 1'b0;
    check("clear_priority", 32'(change_count), 32'h0);

    // 6: reset while a change is 5 counts in
    sw_raw = ~sw_raw;
    edges(7);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_stable", 32'(sw_stable), 32'h0);
    check("async_reset_count", 32'(change_count), 32'h0);
    edges(2);
    sw_raw = 4'hF;
    #1 reset_n = 1'b1;
    edges(9);
    check("relatency_edge9", 32'(sw_stable), 32'h0);
    edges(1);
    check("relatency_edge10", 32'(sw_stable), 32'hF);
    edges(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
